// File: rtl/imem_loader_if.sv
// ---------------------------------------------------------------------------
// imem_loader_if
//
// Bundles the two buses handled by imem_loader:
//   * upstream word stream : s_valid, s_ready, s_addr, s_instr, s_last
//   * core Imem write port : Up, Down, Imem_write_instr, Imem_write_en, start
//
// Modports:
//   master - the loader: consumes the stream and drives the Imem write port.
//   slave  - the environment: the word source plus the core being programmed.
//
// Parameter AW must match the AW of the imem_loader instance it connects to.
// ---------------------------------------------------------------------------
interface imem_loader_if #(
    parameter int AW = 6
);
    logic          s_valid;
    logic          s_ready;
    logic [AW-1:0] s_addr;
    logic [31:0]   s_instr;
    logic          s_last;

    logic          Up;
    logic          Down;
    logic [31:0]   Imem_write_instr;
    logic          Imem_write_en;
    logic          start;

    modport master (
        input  s_valid,
        input  s_addr,
        input  s_instr,
        input  s_last,
        output s_ready,
        output Up,
        output Down,
        output Imem_write_instr,
        output Imem_write_en,
        output start
    );

    modport slave (
        output s_valid,
        output s_addr,
        output s_instr,
        output s_last,
        input  s_ready,
        input  Up,
        input  Down,
        input  Imem_write_instr,
        input  Imem_write_en,
        input  start
    );
endinterface

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Programs the instruction memory of the single-cycle RISC-V core through its
// manual write port. Each accepted (address, instruction) word is written by
// stepping the core write pointer to the target one word per clock, waiting
// SETTLE quiet cycles, and pulsing Imem_write_en for one cycle. After the word
// flagged s_last the pointer is walked back to 0 and start is raised to let
// the core run.
//
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high; the core must be reset in the same
//            cycle so that its pointer returns to 0 together with ptr
//   bus    - imem_loader_if.master (upstream stream + core Imem write port)
//   busy   - high in every state except IDLE and RUN
//   ptr    - loader's copy of the core write pointer
//
// Parameters:
//   DEPTH  - Imem size in 32-bit words, power of two, >= 4
//   AW     - word address width, $clog2(DEPTH)
//   SETTLE - quiet cycles (Up=Down=0) before each write and before start,
//            1..15
//
// Optional feature macro: IMEM_LOADER_SHORTEST_PATH_EN
//   defined   - pointer moves in the wrap-aware shorter direction
//               (ties go Up)
//   undefined - direction by plain unsigned compare, never wraps
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH),
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.master bus,
    output logic          busy,
    output logic [AW-1:0] ptr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_SETTLE,
        S_WRITE,
        S_HOME,
        S_HSETTLE,
        S_RUN
    } state_t;

    // Settle counter counts down to 0, so it is loaded with SETTLE-1.
    localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

    state_t        state_reg;
    logic [AW-1:0] ptr_reg;
    logic [AW-1:0] target_reg;
    logic [31:0]   instr_reg;
    logic          last_reg;
    logic          dir_up_reg;
    logic [3:0]    cnt_reg;
    logic          up_reg;
    logic          down_reg;
    logic          wen_reg;
    logic          start_reg;

    logic          s_ready_int;
    logic          accept;
    logic          dir_to_addr;
    logic          dir_to_home;
    logic [AW-1:0] step_ptr;

    // Direction choice: 1 = Up, 0 = Down. Only evaluated when target != cur.
    function automatic logic pick_up(input logic [AW-1:0] target,
                                     input logic [AW-1:0] cur);
`ifdef IMEM_LOADER_SHORTEST_PATH_EN
        logic [AW-1:0] fwd;
        // Natural AW-bit wrap gives the forward distance modulo DEPTH.
        fwd = target - cur;
        return ({1'b0, fwd} <= (AW+1)'(DEPTH / 2));
`else
        return (target > cur);
`endif
    endfunction

    // s_ready is gated by reset so upstream never sees a handshake while the
    // loader (and the core) are being reset.
    assign s_ready_int = ((state_reg == S_IDLE) || (state_reg == S_RUN)) && !reset;
    assign accept      = bus.s_valid && s_ready_int;

    assign dir_to_addr = pick_up(bus.s_addr, ptr_reg);
    assign dir_to_home = pick_up('0, ptr_reg);

    // Pointer value after the step being issued in the current cycle.
    assign step_ptr = dir_up_reg ? (ptr_reg + AW'(1)) : (ptr_reg - AW'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= S_IDLE;
            ptr_reg    <= '0;
            target_reg <= '0;
            instr_reg  <= '0;
            last_reg   <= 1'b0;
            dir_up_reg <= 1'b0;
            cnt_reg    <= '0;
            up_reg     <= 1'b0;
            down_reg   <= 1'b0;
            wen_reg    <= 1'b0;
            start_reg  <= 1'b0;
        end else begin
            // Mirror the core: its pointer moves on every edge that sees
            // Up or Down high.
            if (up_reg) begin
                ptr_reg <= ptr_reg + AW'(1);
            end else if (down_reg) begin
                ptr_reg <= ptr_reg - AW'(1);
            end

            case (state_reg)
                S_IDLE, S_RUN: begin
                    if (accept) begin
                        start_reg  <= 1'b0;
                        target_reg <= bus.s_addr;
                        instr_reg  <= bus.s_instr;
                        last_reg   <= bus.s_last;
                        if (bus.s_addr != ptr_reg) begin
                            state_reg  <= S_STEP;
                            dir_up_reg <= dir_to_addr;
                            up_reg     <= dir_to_addr;
                            down_reg   <= !dir_to_addr;
                        end else begin
                            state_reg <= S_SETTLE;
                            cnt_reg   <= SETTLE_M1;
                        end
                    end
                end

                S_STEP, S_HOME: begin
                    // Drop the step strobe once the step issued this cycle
                    // lands on the target.
                    if (step_ptr == target_reg) begin
                        up_reg    <= 1'b0;
                        down_reg  <= 1'b0;
                        cnt_reg   <= SETTLE_M1;
                        state_reg <= (state_reg == S_STEP) ? S_SETTLE : S_HSETTLE;
                    end
                end

                S_SETTLE: begin
                    if (cnt_reg == 4'd0) begin
                        wen_reg   <= 1'b1;
                        state_reg <= S_WRITE;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end

                S_WRITE: begin
                    wen_reg <= 1'b0;
                    if (last_reg) begin
                        target_reg <= '0;
                        if (ptr_reg != '0) begin
                            state_reg  <= S_HOME;
                            dir_up_reg <= dir_to_home;
                            up_reg     <= dir_to_home;
                            down_reg   <= !dir_to_home;
                        end else begin
                            state_reg <= S_HSETTLE;
                            cnt_reg   <= SETTLE_M1;
                        end
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end

                S_HSETTLE: begin
                    if (cnt_reg == 4'd0) begin
                        start_reg <= 1'b1;
                        state_reg <= S_RUN;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    up_reg    <= 1'b0;
                    down_reg  <= 1'b0;
                    wen_reg   <= 1'b0;
                    start_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready          = s_ready_int;
    assign bus.Up               = up_reg;
    assign bus.Down             = down_reg;
    assign bus.Imem_write_instr = instr_reg;
    assign bus.Imem_write_en    = wen_reg;
    assign bus.start            = start_reg;

    assign busy = (state_reg != S_IDLE) && (state_reg != S_RUN);
    assign ptr  = ptr_reg;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//
// Directed test-plan steps followed by randomized program words. Expected
// per-cycle behaviour is derived from distances and directions computed with
// plain integer arithmetic, then compared against the DUT every cycle.
// Output vector order: {Up, Down, Imem_write_en, s_ready, start, busy}.
// ---------------------------------------------------------------------------
module tb_imem_loader;
    localparam int DEPTH  = 64;
    localparam int AW     = 6;
    localparam int SETTLE = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          busy;
    logic [AW-1:0] ptr;

    always #5 clk = ~clk;

    imem_loader_if #(.AW(AW)) bus ();

    imem_loader #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .SETTLE(SETTLE)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .busy (busy),
        .ptr  (ptr)
    );

    int checks   = 0;
    int failures = 0;
    int model_ptr = 0;
    bit model_run = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {bus.Up, bus.Down, bus.Imem_write_en, bus.s_ready, bus.start, busy};
    endfunction

    // Direction and step count from 'from' to 'to'.
    function automatic void route(input int from, input int to,
                                  output bit up, output int d);
`ifdef IMEM_LOADER_SHORTEST_PATH_EN
        int f;
        f = (((to - from) % DEPTH) + DEPTH) % DEPTH;
        if (f <= DEPTH / 2) begin
            up = 1'b1;
            d  = f;
        end else begin
            up = 1'b0;
            d  = DEPTH - f;
        end
`else
        if (to >= from) begin
            up = 1'b1;
            d  = to - from;
        end else begin
            up = 1'b0;
            d  = from - to;
        end
`endif
    endfunction

    // Called at a negedge; returns at a negedge with the loader ready again.
    task automatic txn(input int addr, input logic [31:0] instr, input bit last);
        bit          up, hup;
        int          d, h, total, w;
        logic [5:0]  exp;
        w = 0;
        while (bus.s_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_accept", 64'(outs()), 64'({3'b000, 1'b1, model_run, 1'b0}));
        route(model_ptr, addr, up, d);
        route(addr, 0, hup, h);
        total = d + SETTLE + 1 + (last ? (h + SETTLE) : 0);
        bus.s_valid = 1'b1;
        bus.s_addr  = AW'(addr);
        bus.s_instr = instr;
        bus.s_last  = last;
        @(posedge clk);
        @(negedge clk);
        // Garbage on the stream while busy must be ignored.
        bus.s_valid = 1'b1;
        bus.s_addr  = AW'($urandom);
        bus.s_instr = $urandom;
        bus.s_last  = 1'($urandom);
        for (int k = 1; k <= total; k++) begin
            if (k <= d)
                exp = {up, !up, 1'b0, 1'b0, 1'b0, 1'b1};
            else if (k <= d + SETTLE)
                exp = 6'b000001;
            else if (k == d + SETTLE + 1)
                exp = 6'b001001;
            else if (k <= d + SETTLE + 1 + h)
                exp = {hup, !hup, 1'b0, 1'b0, 1'b0, 1'b1};
            else
                exp = 6'b000001;
            check($sformatf("cycle%0d_addr%0d", k, addr), 64'(outs()), 64'(exp));
            if (k == d + SETTLE + 1) begin
                check("write_ptr", 64'(ptr), 64'(addr));
                check("write_instr", 64'(bus.Imem_write_instr), 64'(instr));
            end
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
        model_ptr = last ? 0 : addr;
        model_run = last;
        check("done_outputs", 64'(outs()), 64'({3'b000, 1'b1, last, 1'b0}));
        check("done_ptr", 64'(ptr), 64'(model_ptr));
        check("held_instr", 64'(bus.Imem_write_instr), 64'(instr));
        $display("txn addr=%0d instr=%08h last=%0d steps=%0d home=%0d ptr=%0d",
                 addr, instr, last, d, h, ptr);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.s_valid = 1'b0;
        bus.s_addr  = '0;
        bus.s_instr = '0;
        bus.s_last  = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(outs()), 64'(0));
        check("reset_ptr", 64'(ptr), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Directed steps from the test plan.
        txn(3, 32'h00AE0E13, 1'b0);
        txn(1, 32'h12345678, 1'b0);
        txn(1, 32'hCAFEF00D, 1'b0);
        txn(62, 32'h0BADBEEF, 1'b0);
        txn(0, 32'h00000013, 1'b0);
        txn(5, 32'hDEADBEEF, 1'b1);
        repeat (3) @(negedge clk);
        check("run_held", 64'(outs()), 64'(6'b000110));
        txn(63, 32'h11111111, 1'b0);
        txn(0, 32'h22222222, 1'b1);

        // Randomized words.
        for (int i = 0; i < 24; i++) begin
            txn(int'($urandom_range(0, DEPTH - 1)), $urandom,
                ($urandom_range(0, 4) == 0));
        end

        // Reset during the 2nd STEP cycle of an addr-10 load.
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_ptr = 0;
        model_run = 0;
        bus.s_valid = 1'b1;
        bus.s_addr  = AW'(10);
        bus.s_instr = 32'hA5A5A5A5;
        bus.s_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        check("abort_step1", 64'(outs()), 64'(6'b100001));
        @(negedge clk);
        check("abort_step2", 64'(outs()), 64'(6'b100001));
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", 64'(outs()), 64'(0));
        check("abort_ptr", 64'(ptr), 64'(0));
        check("abort_instr", 64'(bus.Imem_write_instr), 64'(0));
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("post_abort_idle", 64'(outs()), 64'(6'b000100));
            check("post_abort_ptr", 64'(ptr), 64'(0));
        end
        $display("reset abort during addr=10 load ptr=%0d", ptr);

        txn(2, 32'h00500093, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
